instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
// - Fetch-side initiator for the combinational instruction memory: owns the PC, drives
//   imem_address, captures imem_instruction the same cycle.
// - Buffers fetched words in a small FIFO. Presents {instruction, pc} to decode over a
//   valid/ready handshake.
// - Accepts branch/jump redirects from execute.
// PARAMETERS
// - ADDRESS_SIZE      32  width of PC / memory address (bytes)
// - INSTRUCTION_SIZE  32  instruction word width
// - RESET_VECTOR      0   PC value loaded on reset
// - FIFO_DEPTH        2   fetch buffer entries (power of two, >=2)
// PORTS
// - clk               in   1                 rising-edge clock
// - reset             in   1                 asynchronous, active-high reset
// - imem_address      out  ADDRESS_SIZE      byte address to instruction memory (= pc)
// - imem_instruction  in   INSTRUCTION_SIZE  word returned combinationally by memory
// - out_valid         out  1                 FIFO head holds a valid instruction
// - out_ready         in   1                 decode accepts head this cycle
// - out_instruction   out  INSTRUCTION_SIZE  head instruction
// - out_pc            out  ADDRESS_SIZE      byte address of head instruction
// - redirect_valid    in   1                 flush and restart fetch at redirect_target
// - redirect_target   in   ADDRESS_SIZE      new PC; bits [1:0] forced to 0
// - halted            out  1                 fetch stopped (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async, any cycle):
//   - pc=RESET_VECTOR, FIFO count=0, all entries cleared.
//   - out_valid=0, out_instruction=0, out_pc=0, halted=0.
//   - Mid-operation reset discards all buffered words.
// - imem_address = pc at all times; memory read is combinational.
// - Fetch enable: fetch_en = !reset && !halted && !redirect_valid && (count < FIFO_DEPTH).
//   Push is gated on count only, not on pop. DEPTH=2 still sustains 1 instr/cycle.
// - fetch_en in cycle t:
//   - {imem_instruction, pc} is pushed at the edge ending t.
//   - pc <= pc+4, wrapping modulo 2^ADDRESS_SIZE.
//   - The word is visible at out_* in cycle t+1 (1-cycle fetch-to-valid latency).
// - Pop: out_valid && out_ready pops the head at the edge.
//   - Simultaneous push and pop leaves count unchanged.
// - out_* hold stable while out_valid && !out_ready.
// - Redirect in cycle t, which has priority over push and pop:
//   - At the edge: FIFO flushed (count=0), pc <= {redirect_target[AS-1:2],2'b00}, halted <= 0.
//   - Any handshake in cycle t is void.
//   - Target fetched in t+1, visible t+2.
// - Back-to-back redirects: the last one wins. No stale word escapes.
// - Empty: out_valid=0; out_instruction/out_pc hold last head value (don't-care).
// - Full: pc holds, imem_address is stable, no push.
// CONFIGURATION
// - Macro FETCH_HALT_EN defined:
//   - A fetched word equal to all ones ({INSTRUCTION_SIZE{1'b1}}) is not pushed.
//   - pc holds at that address; halted <= 1 at that edge.
//   - Fetch stops. Buffered older words still drain normally.
//   - Only redirect or reset clears halted.
// - Macro undefined: all-ones is an ordinary word (pushed); halted tied to 0.
// TESTING
// - Stream: RESET_VECTOR=4, mem[1..5]=00100093,00200113,00114463,20700193,00300193,
//   out_ready=1. Expect out_pc 4,8,C,10,14 on consecutive cycles starting 1 cycle after
//   reset release, with matching instructions.
// - Backpressure: out_ready=0 for 5 cycles.
//   - count saturates at 2; pc stops at 0xC; out_* hold {00100093,4}.
//   - After release: 4,8,C in order, no duplicate, no loss.
// - Redirect: redirect to 0x13 while FIFO holds 8,C.
//   - Next edge count=0, pc=0x10.
//   - 2 cycles later out_pc=0x10, instr=20700193. 8/C never appear.
// - Redirect + pop same cycle: head is not counted as consumed; flush still occurs.
// - Wrap: RESET_VECTOR=FFFFFFFC. Fetch sequence FFFFFFFC then 0.
// - FETCH_HALT_EN: RESET_VECTOR=0 (mem[0]=FFFFFFFF).
//   - halted=1 after first edge; out_valid stays 0; pc=0.
//   - redirect to 4 clears halted and streams from 4.
//   - Macro off: out_instruction=FFFFFFFF, out_pc=0.
// - Async reset asserted mid-stream between edges: outputs zero immediately, pc=RESET_VECTOR.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner and fetch buffer feeding decode over valid/ready.
// Optional halt-on-all-ones-word behaviour is enabled by defining FETCH_HALT_EN.
module instruction_fetch_unit #(
  parameter int ADDRESS_SIZE                  = 32,
  parameter int INSTRUCTION_SIZE              = 32,
  parameter logic [ADDRESS_SIZE-1:0] RESET_VECTOR = '0,
  parameter int FIFO_DEPTH                    = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic [ADDRESS_SIZE-1:0]     imem_address,
  input  logic [INSTRUCTION_SIZE-1:0] imem_instruction,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INSTRUCTION_SIZE-1:0] out_instruction,
  output logic [ADDRESS_SIZE-1:0]     out_pc,
  input  logic                        redirect_valid,
  input  logic [ADDRESS_SIZE-1:0]     redirect_target,
  output logic                        halted
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  logic [INSTRUCTION_SIZE-1:0] r_fifo_instr [FIFO_DEPTH];
  logic [ADDRESS_SIZE-1:0]     r_fifo_pc    [FIFO_DEPTH];
  logic [PW-1:0]               r_wr_ptr;
  logic [PW-1:0]               r_rd_ptr;
  logic [PW:0]                 r_count;
  logic [ADDRESS_SIZE-1:0]     r_pc;
  logic                        r_halted;

  logic w_full;
  logic w_fetch_en;
  logic w_halt_word;
  logic w_push;
  logic w_pop;
  logic [ADDRESS_SIZE-1:0] w_target;

  assign w_full     = (r_count == DEPTH_C);
  assign w_fetch_en = !r_halted && !redirect_valid && !w_full;

`ifdef FETCH_HALT_EN
  assign w_halt_word = (imem_instruction == {INSTRUCTION_SIZE{1'b1}});
`else
  assign w_halt_word = 1'b0;
`endif

  assign w_push   = w_fetch_en && !w_halt_word;
  // A redirect voids any handshake in the same cycle, so pop is masked too.
  assign w_pop    = (r_count != '0) && out_ready && !redirect_valid;
  assign w_target = redirect_target & ~ADDRESS_SIZE'(3);

  assign imem_address    = r_pc;
  assign out_valid       = (r_count != '0);
  assign out_instruction = r_fifo_instr[r_rd_ptr];
  assign out_pc          = r_fifo_pc[r_rd_ptr];
  assign halted          = r_halted;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= RESET_VECTOR;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_halted <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_instr[i] <= '0;
        r_fifo_pc[i]    <= '0;
      end
    end else if (redirect_valid) begin
      r_pc     <= w_target;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_halted <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo_instr[r_wr_ptr] <= imem_instruction;
        r_fifo_pc[r_wr_ptr]    <= r_pc;
        r_wr_ptr               <= r_wr_ptr + 1'b1;
        r_pc                   <= r_pc + ADDRESS_SIZE'(4);
      end
      if (w_fetch_en && w_halt_word) begin
        r_halted <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halted;

  logic [31:0] wrap_address;
  logic [31:0] wrap_instruction;
  logic        wrap_valid;
  logic        wrap_ready;
  logic [31:0] wrap_out_instruction;
  logic [31:0] wrap_out_pc;
  logic        wrap_redirect_valid;
  logic [31:0] wrap_redirect_target;
  logic        wrap_halted;

  int total_cnt = 0;
  int bad_cnt   = 0;
  logic [63:0] exp_q [$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hFFFF_FFFF;
      32'h0000_0004: return 32'h0010_0093;
      32'h0000_0008: return 32'h0020_0113;
      32'h0000_000C: return 32'h0011_4463;
      32'h0000_0010: return 32'h2070_0193;
      32'h0000_0014: return 32'h0030_0193;
      default:       return 32'h1000_0000 | (a >> 2);
    endcase
  endfunction

  assign imem_instruction = mem_rd(imem_address);
  assign wrap_instruction = mem_rd(wrap_address);

  instruction_fetch_unit #(
    .ADDRESS_SIZE(32), .INSTRUCTION_SIZE(32), .RESET_VECTOR(32'h4), .FIFO_DEPTH(2)
  ) u_dut (
    .clk(clk), .reset(reset), .imem_address(imem_address), .imem_instruction(imem_instruction),
    .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
    .out_pc(out_pc), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halted(halted)
  );

  instruction_fetch_unit #(
    .ADDRESS_SIZE(32), .INSTRUCTION_SIZE(32), .RESET_VECTOR(32'hFFFF_FFFC), .FIFO_DEPTH(2)
  ) u_wrap (
    .clk(clk), .reset(reset), .imem_address(wrap_address), .imem_instruction(wrap_instruction),
    .out_valid(wrap_valid), .out_ready(wrap_ready), .out_instruction(wrap_out_instruction),
    .out_pc(wrap_out_pc), .redirect_valid(wrap_redirect_valid),
    .redirect_target(wrap_redirect_target), .halted(wrap_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] pc);
    exp_q.push_back({mem_rd(pc), pc});
  endtask

  // Called at a falling edge; scores the handshake the next rising edge will perform.
  task automatic tick();
    if (out_valid && out_ready && !redirect_valid && !reset) begin
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("sb_word", {out_instruction, out_pc}, exp_q.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    wrap_ready = 1'b1;
    wrap_redirect_valid = 1'b0;
    wrap_redirect_target = '0;
    repeat (2) @(negedge clk);

    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_instr", 64'(out_instruction), 64'd0);
    check("rst_pc", 64'(out_pc), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_addr", 64'(imem_address), 64'h4);

    // Stream at full rate, plus the wrapping instance running alongside.
    reset = 1'b0;
    out_ready = 1'b1;
    for (int a = 4; a <= 32'h14; a += 4) expect_word(32'(a));
    tick();
    check("wrap_v0", 64'(wrap_valid), 64'd1);
    check("wrap_pc0", 64'(wrap_out_pc), 64'hFFFF_FFFC);
    check("wrap_in0", 64'(wrap_out_instruction), 64'(mem_rd(32'hFFFF_FFFC)));
    tick();
`ifdef FETCH_HALT_EN
    check("wrap_halt", 64'(wrap_halted), 64'd1);
    check("wrap_v1", 64'(wrap_valid), 64'd0);
    check("wrap_addr", 64'(wrap_address), 64'd0);
`else
    check("wrap_v1", 64'(wrap_valid), 64'd1);
    check("wrap_pc1", 64'(wrap_out_pc), 64'd0);
    check("wrap_in1", 64'(wrap_out_instruction), 64'hFFFF_FFFF);
`endif
    repeat (4) tick();
    check("stream_drained", 64'(exp_q.size()), 64'd0);
    out_ready = 1'b0;

    // Asynchronous reset between edges while words are buffered.
    check("pre_areset_valid", 64'(out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("areset_valid", 64'(out_valid), 64'd0);
    check("areset_instr", 64'(out_instruction), 64'd0);
    check("areset_pc", 64'(out_pc), 64'd0);
    check("areset_addr", 64'(imem_address), 64'h4);
    @(negedge clk);
    reset = 1'b0;

    // Backpressure: buffer saturates and holds the head.
    repeat (5) tick();
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_head", {out_instruction, out_pc}, {32'h0010_0093, 32'h4});
    check("bp_addr", 64'(imem_address), 64'hC);
    expect_word(32'h4); expect_word(32'h8); expect_word(32'hC);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Redirect (with a same-cycle pop) while the buffer holds 8 and C.
    pulse_reset();
    repeat (2) tick();
    expect_word(32'h4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check("rd_pre_addr", 64'(imem_address), 64'h10);
    check("rd_pre_head", 64'(out_pc), 64'h8);
    redirect_valid = 1'b1;
    redirect_target = 32'h13;
    out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    check("rd_flush_valid", 64'(out_valid), 64'd0);
    check("rd_addr", 64'(imem_address), 64'h10);
    tick();
    check("rd_valid", 64'(out_valid), 64'd1);
    check("rd_head", {out_instruction, out_pc}, {32'h2070_0193, 32'h10});
    expect_word(32'h10); expect_word(32'h14);
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    check("rd_drained", 64'(exp_q.size()), 64'd0);

    // Back-to-back redirects: the second target wins.
    redirect_valid = 1'b1;
    redirect_target = 32'h8;
    tick();
    redirect_target = 32'h16;
    tick();
    redirect_valid = 1'b0;
    check("b2b_valid", 64'(out_valid), 64'd0);
    check("b2b_addr", 64'(imem_address), 64'h14);
    expect_word(32'h14); expect_word(32'h18);
    tick();
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    check("b2b_drained", 64'(exp_q.size()), 64'd0);

    // All-ones word at address 0.
    redirect_valid = 1'b1;
    redirect_target = 32'h1;
    tick();
    redirect_valid = 1'b0;
    tick();
`ifdef FETCH_HALT_EN
    check("halt_set", 64'(halted), 64'd1);
    check("halt_valid", 64'(out_valid), 64'd0);
    check("halt_addr", 64'(imem_address), 64'd0);
    tick();
    check("halt_hold", 64'(halted), 64'd1);
    check("halt_hold_valid", 64'(out_valid), 64'd0);
    redirect_valid = 1'b1;
    redirect_target = 32'h4;
    tick();
    redirect_valid = 1'b0;
    check("halt_clear", 64'(halted), 64'd0);
    expect_word(32'h4); expect_word(32'h8);
    tick();
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
`else
    check("ones_valid", 64'(out_valid), 64'd1);
    check("ones_head", {out_instruction, out_pc}, {32'hFFFF_FFFF, 32'h0});
    check("ones_halted", 64'(halted), 64'd0);
`endif
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
